// File: rtl/clk_timbase_multi_if.sv
// Bundles the per-channel control inputs and divided-clock outputs of the timer clock base.
// Pure signal container; no logic and no added latency.
// No backpressure; all signals are plain levels/pulses sampled on clk.
interface clk_timbase_multi_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32
);
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       restart;
    logic [NCH*WIDTH-1:0] prescaler;
    logic [NCH-1:0]       clk_tim;
    logic [NCH-1:0]       active;
`ifdef CLK_TIMBASE_TICK_EN
    logic [NCH-1:0]       tick;
`endif

    // Register block side: drives configuration, observes the divided clocks
    modport master (
        output en,
        output restart,
        output prescaler,
        input  clk_tim,
`ifdef CLK_TIMBASE_TICK_EN
        input  tick,
`endif
        input  active
    );

    // Clock-base side
    modport slave (
        input  en,
        input  restart,
        input  prescaler,
        output clk_tim,
`ifdef CLK_TIMBASE_TICK_EN
        output tick,
`endif
        output active
    );
endinterface

// File: rtl/clk_timbase_multi.sv
// NCH-channel programmable clock base: each channel divides clk by its shadowed prescaler into clk_tim.
// Latency: clk_tim/active registered one cycle after the period counter; first high one cycle after enable.
// No backpressure; optional tick output when built with macro CLK_TIMBASE_TICK_EN.
module clk_timbase_multi #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    clk_timbase_multi_if.slave    bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    // Registered per-channel state
    logic [WIDTH-1:0] cnt_q     [NCH];
    logic [WIDTH-1:0] d_act_q   [NCH];
    logic [NCH-1:0]   clk_q;
    logic [NCH-1:0]   act_q;

    // Next-state and per-channel decode
    logic [WIDTH-1:0] cnt_nxt   [NCH];
    logic [WIDTH-1:0] d_act_nxt [NCH];
    logic [WIDTH-1:0] pre_w     [NCH];
    logic [WIDTH-1:0] per_w     [NCH];
    logic [WIDTH-1:0] half_w    [NCH];
    logic [NCH-1:0]   run_w;
    logic [NCH-1:0]   wrap_w;
    logic [NCH-1:0]   load_w;
    logic [NCH-1:0]   clk_nxt;
    logic [NCH-1:0]   act_nxt;

    // Period/phase decode and next-state for every channel; a divisor of 1 runs as clk/2
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pre_w[i]     = bus.prescaler[i*WIDTH +: WIDTH];
            per_w[i]     = (d_act_q[i] == ONE) ? TWO : d_act_q[i];
            half_w[i]    = (per_w[i] >> 1) + WIDTH'(per_w[i][0]);
            run_w[i]     = bus.en[i] && (d_act_q[i] != '0);
            wrap_w[i]    = run_w[i] && (cnt_q[i] == per_w[i] - ONE);
            // Shadow reload only at idle, restart or period boundary, so a
            // mid-period prescaler write never bends the running period
            load_w[i]    = !bus.en[i] || bus.restart[i] || wrap_w[i];
            cnt_nxt[i]   = (run_w[i] && !load_w[i]) ? cnt_q[i] + ONE : '0;
            d_act_nxt[i] = load_w[i] ? pre_w[i] : d_act_q[i];
            clk_nxt[i]   = run_w[i] && (cnt_q[i] < half_w[i]);
            act_nxt[i]   = run_w[i];
        end
    end

    // State update with asynchronous clear of every channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= '0;
                d_act_q[i] <= '0;
            end
            clk_q <= '0;
            act_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= cnt_nxt[i];
                d_act_q[i] <= d_act_nxt[i];
            end
            clk_q <= clk_nxt;
            act_q <= act_nxt;
        end
    end

    assign bus.clk_tim = clk_q;
    assign bus.active  = act_q;

`ifdef CLK_TIMBASE_TICK_EN
    logic [NCH-1:0] tick_q;

    // One-cycle pulse coincident with each clk_tim rising transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= clk_nxt & ~clk_q;
        end
    end

    assign bus.tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_timbase_multi.sv
module tb_clk_timbase_multi;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [W-1:0] pre_v [NCH];

    int tests = 0;
    int fails = 0;

    clk_timbase_multi_if #(.NCH(NCH), .WIDTH(W)) bus ();

    clk_timbase_multi #(.NCH(NCH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.prescaler = {pre_v[3], pre_v[2], pre_v[1], pre_v[0]};

    // ---------------- reference model ----------------
    // Each channel holds the remaining waveform of its current period as a
    // queue of output bits; a new period is generated from the shadow divisor
    // whenever the queue runs dry.
    int           wave_q [NCH][$];
    logic [W-1:0] dsh    [NCH];
    logic [NCH-1:0] exp_clk, exp_act, exp_tick;
    int   p_m, h_m;
    logic o_m;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                wave_q[i].delete();
                dsh[i] = '0;
            end
            exp_clk  = '0;
            exp_act  = '0;
            exp_tick = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                exp_act[i] = bus.en[i] && (dsh[i] != 0);
                o_m = 1'b0;
                if (!bus.en[i]) begin
                    wave_q[i].delete();
                    dsh[i] = pre_v[i];
                end else begin
                    if (dsh[i] != 0) begin
                        if (wave_q[i].size() == 0) begin
                            p_m = (dsh[i] == 1) ? 2 : int'(dsh[i]);
                            h_m = (p_m + 1) / 2;
                            for (int k = 0; k < p_m; k++) wave_q[i].push_back((k < h_m) ? 1 : 0);
                        end
                        o_m = (wave_q[i].pop_front() != 0);
                        if (wave_q[i].size() == 0) dsh[i] = pre_v[i];
                    end
                    if (bus.restart[i]) begin
                        wave_q[i].delete();
                        dsh[i] = pre_v[i];
                    end
                end
                exp_tick[i] = o_m && !exp_clk[i];
                exp_clk[i]  = o_m;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.en = '0;
        bus.restart = '0;
        for (int i = 0; i < NCH; i++) pre_v[i] = 8'd3;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus.en = '1;
        @(negedge clk);
        tests++;
        if (bus.clk_tim !== 4'b0000) begin
            fails++;
            $display("FAIL reset_clk_tim got=%b want=0000", bus.clk_tim);
        end
        tests++;
        if (bus.active !== 4'b0000) begin
            fails++;
            $display("FAIL reset_active got=%b want=0000", bus.active);
        end
        bus.en = '0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_patterns();
        logic [NCH-1:0] e;
        bus.en = '0;
        pre_v[0] = 8'd4; pre_v[1] = 8'd5; pre_v[2] = 8'd1; pre_v[3] = 8'd0;
        @(negedge clk);
        bus.en = '1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            e[0] = (c % 4) < 2;
            e[1] = (c % 5) < 3;
            e[2] = (c % 2) == 0;
            e[3] = 1'b0;
            tests++;
            if (bus.clk_tim !== e) begin
                fails++;
                $display("FAIL patterns_clk cyc=%0d got=%b want=%b", c, bus.clk_tim, e);
            end
            tests++;
            if (bus.active !== 4'b0111) begin
                fails++;
                $display("FAIL patterns_active cyc=%0d got=%b want=0111", c, bus.active);
            end
            tests++;
            if (bus.clk_tim !== exp_clk) begin
                fails++;
                $display("FAIL patterns_model cyc=%0d got=%b want=%b", c, bus.clk_tim, exp_clk);
            end
        end
    endtask

    task automatic test_reload();
        logic e;
        bus.en = '0;
        pre_v[0] = 8'd4;
        @(negedge clk);
        bus.en = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            e = (c < 4) ? (c < 2) : (((c - 4) % 8) < 4);
            tests++;
            if (bus.clk_tim[0] !== e) begin
                fails++;
                $display("FAIL reload cyc=%0d got=%b want=%b", c, bus.clk_tim[0], e);
            end
            if (c == 0) pre_v[0] = 8'd8;
        end
    endtask

    task automatic test_restart();
        logic e;
        bus.en = '0;
        pre_v[0] = 8'd6;
        @(negedge clk);
        bus.en = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            e = (c < 3) ? 1'b1 : (c == 3) ? 1'b0 : (((c - 4) % 6) < 3);
            tests++;
            if (bus.clk_tim[0] !== e) begin
                fails++;
                $display("FAIL restart cyc=%0d got=%b want=%b", c, bus.clk_tim[0], e);
            end
            bus.restart = (c == 2) ? 4'b0001 : 4'b0000;
        end
        bus.restart = '0;
    endtask

    task automatic test_async_reset();
        logic e;
        bus.en = '0;
        pre_v[0] = 8'd10;
        @(negedge clk);
        bus.en = 4'b0001;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if (bus.clk_tim[0] !== 1'b0 || bus.active[0] !== 1'b0) begin
            fails++;
            $display("FAIL async_reset clk_tim=%b active=%b want=0/0", bus.clk_tim[0], bus.active[0]);
        end
        bus.en = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.en = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            e = (c % 10) < 5;
            tests++;
            if (bus.clk_tim[0] !== e || bus.active[0] !== 1'b1) begin
                fails++;
                $display("FAIL async_resume cyc=%0d clk_tim=%b want=%b active=%b", c, bus.clk_tim[0], e, bus.active[0]);
            end
        end
    endtask

`ifdef CLK_TIMBASE_TICK_EN
    task automatic test_tick();
        logic e;
        bus.en = '0;
        pre_v[0] = 8'd3;
        @(negedge clk);
        bus.en = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            e = (c % 3) == 0;
            tests++;
            if (bus.tick[0] !== e) begin
                fails++;
                $display("FAIL tick cyc=%0d got=%b want=%b", c, bus.tick[0], e);
            end
        end
    endtask
`endif

    task automatic test_random();
        int r;
        bus.en = '0;
        bus.restart = '0;
        @(negedge clk);
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            tests++;
            if (bus.clk_tim !== exp_clk || bus.active !== exp_act) begin
                fails++;
                $display("FAIL random cyc=%0d clk_tim=%b want=%b active=%b want=%b",
                         c, bus.clk_tim, exp_clk, bus.active, exp_act);
            end
`ifdef CLK_TIMBASE_TICK_EN
            tests++;
            if (bus.tick !== exp_tick) begin
                fails++;
                $display("FAIL random_tick cyc=%0d got=%b want=%b", c, bus.tick, exp_tick);
            end
`endif
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 39) == 0) bus.en[i] = ~bus.en[i];
                bus.restart[i] = ($urandom_range(0, 23) == 0);
                if ($urandom_range(0, 9) == 0) begin
                    r = $urandom_range(0, 19);
                    if (r == 0)      pre_v[i] = 8'd255;
                    else if (r == 1) pre_v[i] = 8'd254;
                    else             pre_v[i] = 8'($urandom_range(0, 9));
                end
            end
        end
        bus.restart = '0;
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_reload();
        test_restart();
        test_async_reset();
`ifdef CLK_TIMBASE_TICK_EN
        test_tick();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
